// File: rtl/sntc_ldpc_dec_ctrl_if.sv
// sntc_ldpc_dec_ctrl_if: frame-request and result handshakes between host logic and the decode controller
interface sntc_ldpc_dec_ctrl_if #(parameter int CYC_W = 16);
  logic             frm_valid;
  logic             frm_ready;
  logic             res_valid;
  logic             res_ready;
  logic [1:0]       res_status;
  logic [CYC_W-1:0] res_cycles;
  modport master (output frm_valid, res_ready, input frm_ready, res_valid, res_status, res_cycles);
  modport slave  (input frm_valid, res_ready, output frm_ready, res_valid, res_status, res_cycles);
endinterface

// File: rtl/sntc_ldpc_dec_ctrl.sv
// sntc_ldpc_dec_ctrl: per-codeword sequencer for the LDPC decoder with watchdog and pass/fail statistics
module sntc_ldpc_dec_ctrl #(
  parameter int CYC_W    = 16,
  parameter int CNT_W    = 16,
  parameter int MASK_CYC = 2
) (
  input  logic                 clk,
  input  logic                 clr,
  sntc_ldpc_dec_ctrl_if.slave  bus,
  output logic                 q_load,
  output logic                 start_dec,
  input  logic                 converged_loops_ended,
  input  logic                 converged_pass_fail,
  input  logic                 syn_valid_cword_dec,
  input  logic                 abort,
  input  logic [CYC_W-1:0]     timeout_cfg,
  output logic                 dec_busy,
  input  logic                 cnt_clr,
  output logic [CNT_W-1:0]     pass_cnt,
  output logic [CNT_W-1:0]     fail_cnt
);
  typedef enum logic [2:0] {IDLE, LOAD, START, RUN, DONE} state_t;
  localparam logic [CYC_W-1:0] MASK = CYC_W'(MASK_CYC);
  state_t           st, nxt;
  logic [CYC_W-1:0] cyc, cyc_p1, cyc_sat, res_cycles_q;
  logic [1:0]       res_status_q, term_st;
  logic             term, live;
  assign cyc_p1  = cyc + CYC_W'(1);
  assign cyc_sat = &cyc ? cyc : cyc_p1;
  assign live    = cyc >= MASK;
  // termination decision for the current RUN cycle; stale decoder status is ignored until the mask expires
  always_comb begin
    term    = abort | (live & (converged_loops_ended | syn_valid_cword_dec)) |
              (timeout_cfg != '0 && cyc_p1 == timeout_cfg);
    term_st = abort ? 2'b11 :
              (live & converged_loops_ended) ? {1'b0, ~converged_pass_fail} :
              (live & syn_valid_cword_dec) ? 2'b00 : 2'b10;
  end
  // state register
  always_ff @(posedge clk)
    st <= clr ? IDLE : nxt;
  // next-state logic
  always_comb begin
    nxt = st == IDLE  ? (bus.frm_valid ? LOAD : IDLE) :
          st == LOAD  ? START :
          st == START ? RUN :
          st == RUN   ? (term ? DONE : RUN) :
          (bus.res_ready ? IDLE : DONE);
  end
  // state-decoded outputs
  always_comb begin
    bus.frm_ready = st == IDLE;
    q_load        = st == LOAD;
    start_dec     = st == START;
    bus.res_valid = st == DONE;
    dec_busy      = st == LOAD || st == START || st == RUN;
  end
  // run-cycle counter and result capture on termination
  always_ff @(posedge clk) begin
    if (clr) begin
      cyc          <= '0;
      res_status_q <= '0;
      res_cycles_q <= '0;
    end else begin
      cyc <= st == START ? '0 : st == RUN ? cyc_sat : cyc;
      if (st == RUN && term) begin
        res_status_q <= term_st;
        res_cycles_q <= cyc_sat;
      end
    end
  end
  assign bus.res_status = res_status_q;
  assign bus.res_cycles = res_cycles_q;
  // saturating statistics; a clear wins over a coincident increment, aborts are not counted
  always_ff @(posedge clk) begin
    if (clr || cnt_clr) begin
      pass_cnt <= '0;
      fail_cnt <= '0;
    end else if (st == RUN && term) begin
      if (term_st == 2'b00 && !(&pass_cnt)) pass_cnt <= pass_cnt + CNT_W'(1);
      if ((term_st == 2'b01 || term_st == 2'b10) && !(&fail_cnt)) fail_cnt <= fail_cnt + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_sntc_ldpc_dec_ctrl.sv
// tb_sntc_ldpc_dec_ctrl: directed plus randomized frames checked against an event-schedule reference model
module tb_sntc_ldpc_dec_ctrl;
  localparam int CYC_W = 16;
  localparam int CNT_W = 2;
  localparam int CMAX  = 3;
  logic clk = 0;
  logic clr, q_load, start_dec, loops, pf, syn, abort, dec_busy, cnt_clr;
  logic [CYC_W-1:0] timeout_cfg;
  logic [CNT_W-1:0] pass_cnt, fail_cnt;
  int checks = 0, failures = 0;
  int pass_m = 0, fail_m = 0;
  sntc_ldpc_dec_ctrl_if #(.CYC_W(CYC_W)) bus ();
  sntc_ldpc_dec_ctrl #(.CYC_W(CYC_W), .CNT_W(CNT_W), .MASK_CYC(2)) dut (
    .clk(clk), .clr(clr), .bus(bus), .q_load(q_load), .start_dec(start_dec),
    .converged_loops_ended(loops), .converged_pass_fail(pf), .syn_valid_cword_dec(syn),
    .abort(abort), .timeout_cfg(timeout_cfg), .dec_busy(dec_busy), .cnt_clr(cnt_clr),
    .pass_cnt(pass_cnt), .fail_cnt(fail_cnt));
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Walk RUN cycles k=0,1,.. applying the termination rules in priority order.
  task automatic model(input int ab, lp, fpf, sy, tmo, output int st, output int cyc);
    st = -1;
    cyc = 0;
    for (int k = 0; k < 60000 && st < 0; k++) begin
      if (k == ab) st = 3;
      else if (k >= 2 && lp >= 0 && k >= lp) st = fpf ? 0 : 1;
      else if (k >= 2 && sy >= 0 && k >= sy) st = 0;
      else if (tmo != 0 && k + 1 == tmo) st = 2;
      cyc = k + 1;
    end
  endtask

  // One frame: ab/lp/sy/cc are RUN-cycle indices (-1 = never), hold = cycles of result backpressure.
  task automatic run_frame(input int ab, lp, fpf, sy, tmo, cc, hold);
    int es, ec, k;
    bit done;
    model(ab, lp, fpf, sy, tmo, es, ec);
    timeout_cfg = tmo[CYC_W-1:0];
    chk("frm_ready_idle", bus.frm_ready, 1);
    bus.frm_valid = 1;
    syn = (sy == 0);
    @(negedge clk);
    bus.frm_valid = 0;
    chk("q_load_t1", q_load, 1);
    chk("frm_ready_busy", bus.frm_ready, 0);
    chk("dec_busy_load", dec_busy, 1);
    @(negedge clk);
    chk("start_dec_t2", start_dec, 1);
    chk("q_load_once", q_load, 0);
    k = 0;
    done = 0;
    while (!done && k < 5000) begin
      @(negedge clk);
      if (bus.res_valid) done = 1;
      else begin
        if (k % 64 == 0) chk("dec_busy_run", dec_busy, 1);
        abort   = (k == ab);
        loops   = (lp >= 0 && k >= lp);
        pf      = fpf[0];
        syn     = (sy >= 0 && k >= sy);
        cnt_clr = (k == cc);
        k++;
      end
    end
    abort = 0; loops = 0; syn = 0; cnt_clr = 0;
    if (!done) begin
      chk("term_bound", 0, 1);
      return;
    end
    chk("term_latency", k, ec);
    if (cc >= 0 && cc < ec) begin pass_m = 0; fail_m = 0; end
    if (cc != ec - 1) begin
      if (es == 0 && pass_m < CMAX) pass_m++;
      if ((es == 1 || es == 2) && fail_m < CMAX) fail_m++;
    end
    for (int i = 0; i <= hold; i++) begin
      chk("res_valid", bus.res_valid, 1);
      chk("res_status", bus.res_status, es);
      chk("res_cycles", bus.res_cycles, ec);
      chk("frm_ready_done", bus.frm_ready, 0);
      chk("dec_busy_done", dec_busy, 0);
      if (i < hold) begin
        bus.frm_valid = 1;
        abort = 1;
        @(negedge clk);
      end
    end
    bus.frm_valid = 0;
    abort = 0;
    bus.res_ready = 1;
    @(negedge clk);
    bus.res_ready = 0;
    chk("res_valid_drop", bus.res_valid, 0);
    chk("frm_ready_back", bus.frm_ready, 1);
    chk("pass_cnt", pass_cnt, pass_m);
    chk("fail_cnt", fail_cnt, fail_m);
  endtask

  initial begin
    clr = 1; bus.frm_valid = 0; bus.res_ready = 0; loops = 0; pf = 0; syn = 0;
    abort = 0; cnt_clr = 0; timeout_cfg = '0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_frm_ready", bus.frm_ready, 1);
    chk("rst_q_load", q_load, 0);
    chk("rst_start_dec", start_dec, 0);
    chk("rst_res_valid", bus.res_valid, 0);
    chk("rst_res_status", bus.res_status, 0);
    chk("rst_res_cycles", bus.res_cycles, 0);
    chk("rst_dec_busy", dec_busy, 0);
    chk("rst_pass_cnt", pass_cnt, 0);
    chk("rst_fail_cnt", fail_cnt, 0);
    clr = 0;
    @(negedge clk);
    run_frame(-1, -1, 0, 5, 0, -1, 0);
    run_frame(-1, 20, 0, -1, 0, -1, 0);
    run_frame(-1, 10, 1, 0, 0, -1, 0);
    run_frame(-1, -1, 0, -1, 8, -1, 0);
    run_frame(1000, -1, 0, -1, 0, -1, 0);
    run_frame(10, 10, 1, -1, 0, -1, 30);
    run_frame(-1, -1, 0, -1, 1, -1, 0);
    run_frame(0, 0, 1, 0, 0, -1, 0);
    bus.frm_valid = 1;
    @(negedge clk);
    bus.frm_valid = 0;
    repeat (4) @(negedge clk);
    clr = 1;
    @(negedge clk);
    clr = 0;
    pass_m = 0; fail_m = 0;
    chk("clr_frm_ready", bus.frm_ready, 1);
    chk("clr_dec_busy", dec_busy, 0);
    chk("clr_res_valid", bus.res_valid, 0);
    chk("clr_res_status", bus.res_status, 0);
    chk("clr_res_cycles", bus.res_cycles, 0);
    chk("clr_pass_cnt", pass_cnt, 0);
    chk("clr_fail_cnt", fail_cnt, 0);
    repeat (5) @(negedge clk);
    chk("clr_no_result", bus.res_valid, 0);
    repeat (5) run_frame(-1, -1, 0, 3, 0, -1, 0);
    run_frame(-1, -1, 0, 3, 0, 3, 0);
    run_frame(-1, 4, 0, -1, 0, 1, 0);
    for (int n = 0; n < 30; n++) begin
      int ab, lp, fpf, sy, tmo, cc;
      ab  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 30)) : -1;
      lp  = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 30)) : -1;
      fpf = int'($urandom_range(0, 1));
      sy  = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 30)) : -1;
      tmo = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 40));
      cc  = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 10)) : -1;
      if (ab < 0 && lp < 0 && sy < 0 && tmo == 0) tmo = 25;
      run_frame(ab, lp, fpf, sy, tmo, cc, int'($urandom_range(0, 3)));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
